// File: rtl/fir_output_decimator.sv
// Accumulate-and-dump decimator: sums DECIM valid samples, rounds half-up, saturates to OUT_W, queues in a FIFO.
// Result is visible one edge after the dump sample; a full FIFO without a same-cycle pop drops the result.

module fir_output_decimator_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_vld,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop,
   output logic [W-1:0]                 head_dat,
   output logic                         head_vld,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign head_vld = (cnt_q != '0);
   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign head_dat = mem_q[rd_ptr_q];
   assign count    = cnt_q;
   assign do_pop   = pop && head_vld;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push  = push_vld && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

module fir_output_decimator #(
   parameter int DECIM      = 4,
   parameter int SHIFT      = 2,
   parameter int OUT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic signed [15:0]                  y_in,
   input  logic                                in_valid,
   output logic signed [OUT_W-1:0]             out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
   output logic                                overflow,
   output logic                                drop
);
   localparam int PH_W  = $clog2(DECIM);
   localparam int ACC_W = 16 + $clog2(DECIM);
   localparam int RND_W = ACC_W + 1;
   localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** (SHIFT - 1));
   localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN  = ~SAT_MAX;

   logic [PH_W-1:0]         phase_q, phase_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    overflow_q, overflow_d;
   logic                    drop_q, drop_d;
   logic signed [ACC_W-1:0] sum;
   logic signed [RND_W-1:0] rnd;
   logic signed [RND_W-1:0] shr;
   logic                    sat_hi, sat_lo;
   logic [OUT_W-1:0]        res;
   logic                    dump;
   logic                    pop;
   logic                    fifo_full;
   logic [OUT_W-1:0]        head_dat;

   assign dump = in_valid && (phase_q == PH_W'(DECIM - 1));
   assign pop  = out_valid && out_ready;

   // One extra bit keeps the rounding add from wrapping at the extremes.
   always_comb begin
      sum    = acc_q + {{(ACC_W-16){y_in[15]}}, y_in};
      rnd    = {sum[ACC_W-1], sum} + RND_HALF;
      shr    = rnd >>> SHIFT;
      sat_hi = (shr > SAT_MAX);
      sat_lo = (shr < SAT_MIN);
      if (sat_hi) begin
         res = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (sat_lo) begin
         res = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         res = shr[OUT_W-1:0];
      end
   end

   always_comb begin
      phase_d    = phase_q;
      acc_d      = acc_q;
      overflow_d = overflow_q | (dump & (sat_hi | sat_lo));
      drop_d     = dump && fifo_full && !pop;
      if (in_valid) begin
         if (dump) begin
            phase_d = '0;
            acc_d   = '0;
         end else begin
            phase_d = phase_q + PH_W'(1);
            acc_d   = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q    <= '0;
         acc_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         acc_q      <= acc_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   fir_output_decimator_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (dump),
      .push_dat (res),
      .pop      (pop),
      .head_dat (head_dat),
      .head_vld (out_valid),
      .full     (fifo_full),
      .count    (count)
   );

   assign out_data = head_dat;
   assign overflow = overflow_q;
   assign drop     = drop_q;
endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator with DECIM=4, SHIFT=2, OUT_W=8, FIFO_DEPTH=4.
module tb_fir_output_decimator;
   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic signed [15:0] y_in = '0;
   logic              in_valid = 1'b0;
   logic signed [7:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [2:0]        count;
   logic              overflow;
   logic              drop;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int   y;
      logic vi;
      logic e_vld;
      int   e_dat;
      int   e_cnt;
      logic e_ovf;
   } vec_t;

   vec_t vecs[$];

   fir_output_decimator #(
      .DECIM(4), .SHIFT(2), .OUT_W(8), .FIFO_DEPTH(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .y_in      (y_in),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic step(input int y, input logic vi, input logic rdy);
      y_in      = 16'(y);
      in_valid  = vi;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int y, input logic vi, input logic e_vld, input int e_dat,
                      input int e_cnt, input logic e_ovf);
      vec_t v;
      v.y = y; v.vi = vi; v.e_vld = e_vld; v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
      vecs.push_back(v);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".out_valid"}, int'(out_valid), 0);
      chk({tag, ".out_data"},  int'(out_data), 0);
      chk({tag, ".count"},     int'(count), 0);
      chk({tag, ".overflow"},  int'(overflow), 0);
      chk({tag, ".drop"},      int'(drop), 0);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      #2 chk_reset_outputs("rst");
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic feed_block(input int a, input int b, input int c, input int d, input logic rdy_last);
      step(a, 1'b1, 1'b0);
      step(b, 1'b1, 1'b0);
      step(c, 1'b1, 1'b0);
      step(d, 1'b1, rdy_last);
   endtask

   initial begin
      int exp_heads[4];

      // Reset state while held
      #12;
      chk_reset_outputs("init");
      @(posedge clk);
      #1 reset = 1'b1;

      // Basic block 1,2,3,4 -> 3
      add(1, 1, 0, 0, 0, 0); add(2, 1, 0, 0, 0, 0); add(3, 1, 0, 0, 0, 0);
      add(4, 1, 1, 3, 1, 0);
      // -1..-4: sum -10 rounds half-up to -2
      add(-1, 1, 0, 0, 0, 0); add(-2, 1, 0, 0, 0, 0); add(-3, 1, 0, 0, 0, 0);
      add(-4, 1, 1, -2, 1, 0);
      // sum 10 rounds to 3
      add(2, 1, 0, 0, 0, 0); add(3, 1, 0, 0, 0, 0); add(3, 1, 0, 0, 0, 0);
      add(2, 1, 1, 3, 1, 0);
      // Positive then negative saturation
      add(1000, 1, 0, 0, 0, 0); add(1000, 1, 0, 0, 0, 0); add(1000, 1, 0, 0, 0, 0);
      add(1000, 1, 1, 127, 1, 1);
      add(-1000, 1, 0, 0, 0, 1); add(-1000, 1, 0, 0, 0, 1); add(-1000, 1, 0, 0, 0, 1);
      add(-1000, 1, 1, -128, 1, 1);
      // Gapped block; junk on idle cycles must be ignored
      add(1, 1, 0, 0, 0, 1); add(99, 0, 0, 0, 0, 1); add(2, 1, 0, 0, 0, 1);
      add(99, 0, 0, 0, 0, 1); add(3, 1, 0, 0, 0, 1); add(-99, 0, 0, 0, 0, 1);
      add(4, 1, 1, 3, 1, 1);
      add(0, 0, 0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         string nm;
         step(vecs[i].y, vecs[i].vi, 1'b1);
         nm = $sformatf("vec%0d", i);
         chk({nm, ".out_valid"}, int'(out_valid), int'(vecs[i].e_vld));
         if (vecs[i].e_vld) chk({nm, ".out_data"}, int'(out_data), vecs[i].e_dat);
         chk({nm, ".count"},    int'(count), vecs[i].e_cnt);
         chk({nm, ".overflow"}, int'(overflow), int'(vecs[i].e_ovf));
         chk({nm, ".drop"},     int'(drop), 0);
      end

      // Back-pressure: fill, drop on 5th dump, then drain
      do_reset();
      for (int blk = 1; blk <= 5; blk++) begin
         feed_block(1, 2, 3, 4, 1'b0);
         if (blk <= 4) begin
            chk($sformatf("bp.count%0d", blk), int'(count), blk);
            chk($sformatf("bp.drop%0d", blk), int'(drop), 0);
            chk($sformatf("bp.data%0d", blk), int'(out_data), 3);
         end else begin
            chk("bp.drop5", int'(drop), 1);
            chk("bp.count5", int'(count), 4);
         end
      end
      step(0, 1'b0, 1'b0);
      chk("bp.drop_pulse", int'(drop), 0);
      chk("bp.count_hold", int'(count), 4);
      chk("bp.ovf", int'(overflow), 0);
      for (int k = 3; k >= 0; k--) begin
         chk($sformatf("bp.head%0d", k), int'(out_data), 3);
         step(0, 1'b0, 1'b1);
         chk($sformatf("bp.drain_count%0d", k), int'(count), k);
      end
      chk("bp.empty_valid", int'(out_valid), 0);

      // Push and pop together while full
      do_reset();
      feed_block(10, 10, 10, 10, 1'b0);
      feed_block(20, 20, 20, 20, 1'b0);
      feed_block(30, 30, 30, 30, 1'b0);
      feed_block(40, 40, 40, 40, 1'b0);
      chk("pp.full_count", int'(count), 4);
      chk("pp.head_stable", int'(out_data), 10);
      feed_block(50, 50, 50, 50, 1'b1);
      chk("pp.drop", int'(drop), 0);
      chk("pp.count", int'(count), 4);
      exp_heads[0] = 20; exp_heads[1] = 30; exp_heads[2] = 40; exp_heads[3] = 50;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp.head%0d", k), int'(out_valid), 1);
         chk($sformatf("pp.data%0d", k), int'(out_data), exp_heads[k]);
         step(0, 1'b0, 1'b1);
      end
      chk("pp.empty_valid", int'(out_valid), 0);
      chk("pp.empty_count", int'(count), 0);

      // Reset mid-block discards partial sum and clears all state
      do_reset();
      feed_block(1000, 1000, 1000, 1000, 1'b0);
      chk("mr.pre_ovf", int'(overflow), 1);
      chk("mr.pre_count", int'(count), 1);
      step(7, 1'b1, 1'b0);
      step(9, 1'b1, 1'b0);
      in_valid = 1'b0;
      reset = 1'b0;
      #2 chk_reset_outputs("mr");
      @(posedge clk);
      #1 reset = 1'b1;
      feed_block(4, 4, 4, 4, 1'b1);
      chk("mr.valid", int'(out_valid), 1);
      chk("mr.data", int'(out_data), 4);
      chk("mr.ovf", int'(overflow), 0);
      step(0, 1'b0, 1'b1);
      chk("mr.drained", int'(out_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_output_decimator.md
# fir_output_decimator

Downstream stage of `fir_filter`. Consumes the filter's signed 16-bit output stream, accumulates and dumps every DECIM valid samples, requantizes the sum with round-half-up and saturation to OUT_W bits, and buffers results in a small FIFO with a valid/ready output handshake. It decouples the filter's fixed sample rate from a slower, back-pressuring sink.

## Interface
- DECIM, 4: decimation factor (samples per output). Must be ≥2.
- SHIFT, 2: arithmetic right shift applied to the accumulated sum. Must be ≥1.
- OUT_W, 8: output sample width, signed.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2, ≥2.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- y_in  in  16  signed filter output sample.
- in_valid  in  1  y_in carries a valid sample this cycle. No back-pressure to the filter.
- out_data  out  OUT_W  signed FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts out_data this cycle.
- count  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one result saturated.
- drop  out  1  one-cycle pulse: a result was discarded because the FIFO was full.

## Operation
- Phase counter 0..DECIM-1 and accumulator (signed, 16+clog2(DECIM) bits) advance only on cycles where in_valid=1. in_valid=0 holds both.
- Phase < DECIM-1: acc <= acc + y_in, phase increments.
- Phase = DECIM-1 (dump): sum = acc + y_in. The result is written to the FIFO, acc <= 0, and phase <= 0.
- Requantization: r = (sum + 2^(SHIFT-1)) >>> SHIFT, with the add at full width (no intermediate overflow). The rounding is half-up, toward +inf: -2.5 → -2 and 2.5 → 3.
- Saturation: r clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clamp sets overflow, which stays set until reset.
- FIFO:
  - Push on dump.
  - Pop when out_valid && out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Full and dump without pop: the result is discarded, drop=1 for that cycle, and count and contents are unchanged. overflow is still updated from the discarded result.
- Full, dump, and pop in the same cycle: both happen, no drop, and count stays FIFO_DEPTH.
- Empty: a pop cannot occur because out_valid=0. There is no fall-through; a pushed word is visible the cycle after the push.
- Reset, including mid-block: the partial accumulation is discarded and all state is cleared.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_data=0, count=0, overflow=0, drop=0.
  - Internal state: phase=0, acc=0, pointers=0.
- Latency: if the dump sample is on edge N, out_valid=1 and out_data=r after edge N, provided the FIFO was empty.
- out_data equals mem[rd_ptr] whenever out_valid=1. It holds stable while out_valid && !out_ready.
- A pop on edge N presents the next entry (or out_valid=0) after edge N.
- count changes by +1 (push only), -1 (pop only), or 0 (push and pop, neither, or dropped push). It is registered and updates at the same edge as the pointers.
- drop and overflow are registered and assert after the dump edge.
- Sustained throughput: one output per DECIM valid inputs, and one pop per cycle maximum.

## Test plan
- Basic: DECIM=4, SHIFT=2, out_ready=1. Input 1,2,3,4 with in_valid=1 → out_data=3 (sum 10, +2, >>2), out_valid high for 1 cycle after the 4th edge, overflow=0.
- Negative rounding: input -1,-2,-3,-4 → out_data=-2 (sum -10 → -8>>>2). Then 2,3,3,2 → out_data=3 (sum 10 → 12>>2).
- Saturation: four samples of 1000 → out_data=127 and overflow=1. Then four samples of -1000 → out_data=-128, and overflow remains 1.
- Back-pressure/full: out_ready=0, feed 5 blocks of 1,2,3,4.
  - count goes 1,2,3,4.
  - The 5th dump pulses drop for 1 cycle.
  - Then out_ready=1 drains four 3s, count goes to 0, and out_valid falls.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the dump cycle → no drop, count stays 4, next-in-order data out.
- Gaps and reset: in_valid toggling 1/0 across a block yields the same result as contiguous input. Feeding 2 samples, pulsing reset low for 1 cycle, then 4,4,4,4 → out_data=4. The earlier partial sum is discarded, and all outputs read 0 during reset.
